// File: rtl/rob_pkg.sv
// Shared constants and entry type for the reorder buffer.
package rob_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = 6;
    localparam int IDX_W     = $clog2(ROB_DEPTH);

    // Tag 0 is the architectural x0 and is never a real producer.
    localparam logic [TAG_W-1:0] NO_TAG = '0;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [TAG_W-1:0] physical_rd;
        logic [TAG_W-1:0] old_physical_rd;
    } rob_entry_t;

endpackage

// File: rtl/rob_wakeup_match.sv
// Combinational compare of one entry tag against the four FU broadcasts.
// Tag 0 never matches, so x0 broadcasts cannot mark anything done.
module rob_wakeup_match
    import rob_pkg::*;
(
    input  logic [TAG_W-1:0]      entry_tag_i,
    input  logic [3:0]            wakeup_active_i,
    input  logic [3:0][TAG_W-1:0] wakeup_tag_i,
    output logic                  hit_o
);

    // Any active broadcast of this (nonzero) tag is a hit.
    always_comb begin
        hit_o = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (wakeup_active_i[k] && (wakeup_tag_i[k] == entry_tag_i) &&
                (entry_tag_i != NO_TAG)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocate at tail, mark done on FU wakeup,
// retire up to two entries per cycle from head and return their old tags.
// Optional macro ROB_WAKEUP_BYPASS_EN lets a head/head+1 entry retire on the
// same edge as its wakeup broadcast.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alloc_valid,
    input  logic [TAG_W-1:0] alloc_physical_rd,
    input  logic [TAG_W-1:0] alloc_old_physical_rd,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_index,
    input  logic             wakeup_0_active,
    input  logic [TAG_W-1:0] wakeup_0_tag,
    input  logic             wakeup_1_active,
    input  logic [TAG_W-1:0] wakeup_1_tag,
    input  logic             wakeup_2_active,
    input  logic [TAG_W-1:0] wakeup_2_tag,
    input  logic             wakeup_3_active,
    input  logic [TAG_W-1:0] wakeup_3_tag,
    output logic [TAG_W-1:0] freed_tag_1,
    output logic [TAG_W-1:0] freed_tag_2,
    output logic [1:0]       retire_count,
    output logic             rob_empty,
    output logic             rob_full
);

    logic [3:0]            wk_active;
    logic [3:0][TAG_W-1:0] wk_tag;

    assign wk_active = {wakeup_3_active, wakeup_2_active, wakeup_1_active, wakeup_0_active};
    assign wk_tag    = {wakeup_3_tag, wakeup_2_tag, wakeup_1_tag, wakeup_0_tag};

    rob_entry_t       entries_q [ROB_DEPTH];
    rob_entry_t       entries_d [ROB_DEPTH];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [TAG_W-1:0] freed_1_q, freed_1_d;
    logic [TAG_W-1:0] freed_2_q, freed_2_d;
    logic [1:0]       retire_cnt_q, retire_cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;

    logic [ROB_DEPTH-1:0] wake_hit;
    logic [IDX_W-1:0]     head1;
    rob_entry_t           head_e, head1_e;
    logic                 head_ready, head1_ready;
    logic                 ret0, ret1;
    logic                 alloc_fire;

    // One broadcast comparator per entry.
    generate
        for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_match
            rob_wakeup_match u_match (
                .entry_tag_i     (entries_q[gi].physical_rd),
                .wakeup_active_i (wk_active),
                .wakeup_tag_i    (wk_tag),
                .hit_o           (wake_hit[gi])
            );
        end
    endgenerate

    assign head1   = head_q + IDX_W'(1);
    assign head_e  = entries_q[head_q];
    assign head1_e = entries_q[head1];

`ifdef ROB_WAKEUP_BYPASS_EN
    logic byp_hit0, byp_hit1;

    rob_wakeup_match u_byp0 (
        .entry_tag_i     (head_e.physical_rd),
        .wakeup_active_i (wk_active),
        .wakeup_tag_i    (wk_tag),
        .hit_o           (byp_hit0)
    );

    rob_wakeup_match u_byp1 (
        .entry_tag_i     (head1_e.physical_rd),
        .wakeup_active_i (wk_active),
        .wakeup_tag_i    (wk_tag),
        .hit_o           (byp_hit1)
    );

    assign head_ready  = head_e.valid  && (head_e.done  || byp_hit0);
    assign head1_ready = head1_e.valid && (head1_e.done || byp_hit1);
`else
    assign head_ready  = head_e.valid  && head_e.done;
    assign head1_ready = head1_e.valid && head1_e.done;
`endif

    // Full check uses registered state only: retirement this edge never
    // frees space for this edge's allocation.
    assign alloc_fire = alloc_valid && !full_q;
    assign ret0       = head_ready;
    assign ret1       = ret0 && head1_ready;

    // Pointer, count and registered-output next state.
    always_comb begin
        retire_cnt_d = ret1 ? 2'd2 : (ret0 ? 2'd1 : 2'd0);
        head_d       = head_q + IDX_W'(retire_cnt_d);
        tail_d       = tail_q + IDX_W'(alloc_fire);
        count_d      = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(retire_cnt_d);
        full_d       = (count_d == (IDX_W+1)'(ROB_DEPTH));
        empty_d      = (count_d == '0);
        freed_1_d    = ret0 ? head_e.old_physical_rd  : NO_TAG;
        freed_2_d    = ret1 ? head1_e.old_physical_rd : NO_TAG;
    end

    // Per-entry update. A slot at tail is always free when allocation fires,
    // so allocation and retirement never target the same entry.
    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (alloc_fire && (tail_q == IDX_W'(i))) begin
                entries_d[i].valid           = 1'b1;
                entries_d[i].done            = (alloc_physical_rd == NO_TAG);
                entries_d[i].physical_rd     = alloc_physical_rd;
                entries_d[i].old_physical_rd = alloc_old_physical_rd;
            end else if ((ret0 && (head_q == IDX_W'(i))) ||
                         (ret1 && (head1  == IDX_W'(i)))) begin
                entries_d[i] = '0;
            end else if (entries_q[i].valid && !entries_q[i].done && wake_hit[i]) begin
                entries_d[i].done = 1'b1;
            end
        end
    end

    // State register; reset discards every entry without freeing tags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            freed_1_q    <= NO_TAG;
            freed_2_q    <= NO_TAG;
            retire_cnt_q <= 2'd0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            freed_1_q    <= freed_1_d;
            freed_2_q    <= freed_2_d;
            retire_cnt_q <= retire_cnt_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
        end
    end

    assign alloc_ready  = !full_q;
    assign alloc_index  = tail_q;
    assign freed_tag_1  = freed_1_q;
    assign freed_tag_2  = freed_2_q;
    assign retire_count = retire_cnt_q;
    assign rob_empty    = empty_q;
    assign rob_full     = full_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: queue-based model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_reorder_buffer;

    localparam int DEPTH = 16;

`ifdef ROB_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       alloc_valid;
    logic [5:0] alloc_physical_rd;
    logic [5:0] alloc_old_physical_rd;
    logic       alloc_ready;
    logic [3:0] alloc_index;
    logic       wakeup_0_active, wakeup_1_active, wakeup_2_active, wakeup_3_active;
    logic [5:0] wakeup_0_tag, wakeup_1_tag, wakeup_2_tag, wakeup_3_tag;
    logic [5:0] freed_tag_1, freed_tag_2;
    logic [1:0] retire_count;
    logic       rob_empty, rob_full;

    reorder_buffer dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .alloc_valid           (alloc_valid),
        .alloc_physical_rd     (alloc_physical_rd),
        .alloc_old_physical_rd (alloc_old_physical_rd),
        .alloc_ready           (alloc_ready),
        .alloc_index           (alloc_index),
        .wakeup_0_active       (wakeup_0_active),
        .wakeup_0_tag          (wakeup_0_tag),
        .wakeup_1_active       (wakeup_1_active),
        .wakeup_1_tag          (wakeup_1_tag),
        .wakeup_2_active       (wakeup_2_active),
        .wakeup_2_tag          (wakeup_2_tag),
        .wakeup_3_active       (wakeup_3_active),
        .wakeup_3_tag          (wakeup_3_tag),
        .freed_tag_1           (freed_tag_1),
        .freed_tag_2           (freed_tag_2),
        .retire_count          (retire_count),
        .rob_empty             (rob_empty),
        .rob_full              (rob_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: in-order list of live instructions
    typedef struct {
        logic [5:0] prd;
        logic [5:0] old;
        bit         done;
    } m_ent_t;

    m_ent_t     mq[$];
    int         m_tail = 0;
    logic [5:0] m_f1 = 0, m_f2 = 0;
    int         m_rc = 0;

    function automatic bit woken(input logic [5:0] t);
        return (t != 0) &&
               ((wakeup_0_active && wakeup_0_tag == t) || (wakeup_1_active && wakeup_1_tag == t) ||
                (wakeup_2_active && wakeup_2_tag == t) || (wakeup_3_active && wakeup_3_tag == t));
    endfunction

    initial begin : model
        int     pre;
        int     n;
        m_ent_t e;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                m_tail = 0; m_f1 = 0; m_f2 = 0; m_rc = 0;
            end else begin
                pre = mq.size();
                n   = 0;
                if (pre > 0 && (mq[0].done || (BYP && woken(mq[0].prd)))) begin
                    n = 1;
                    if (pre > 1 && (mq[1].done || (BYP && woken(mq[1].prd)))) n = 2;
                end
                m_f1 = (n >= 1) ? mq[0].old : 6'd0;
                m_f2 = (n >= 2) ? mq[1].old : 6'd0;
                m_rc = n;
                for (int i = 0; i < n; i++) void'(mq.pop_front());
                for (int i = 0; i < mq.size(); i++)
                    if (woken(mq[i].prd)) mq[i].done = 1'b1;
                if (alloc_valid && pre < DEPTH) begin
                    e.prd  = alloc_physical_rd;
                    e.old  = alloc_old_physical_rd;
                    e.done = (alloc_physical_rd == 0);
                    mq.push_back(e);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("cmp_freed1",  freed_tag_1,  m_f1);
            chk("cmp_freed2",  freed_tag_2,  m_f2);
            chk("cmp_rc",      retire_count, m_rc);
            chk("cmp_empty",   rob_empty,    mq.size() == 0);
            chk("cmp_full",    rob_full,     mq.size() == DEPTH);
            chk("cmp_ready",   alloc_ready,  mq.size() != DEPTH);
            chk("cmp_index",   alloc_index,  m_tail);
        end
    end

    // ---------------- stimulus helpers
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clr;
        alloc_valid = 0; alloc_physical_rd = 0; alloc_old_physical_rd = 0;
        wakeup_0_active = 0; wakeup_0_tag = 0; wakeup_1_active = 0; wakeup_1_tag = 0;
        wakeup_2_active = 0; wakeup_2_tag = 0; wakeup_3_active = 0; wakeup_3_tag = 0;
    endtask

    task automatic alloc(input logic [5:0] prd, input logic [5:0] old);
        alloc_valid = 1; alloc_physical_rd = prd; alloc_old_physical_rd = old;
    endtask

    task automatic wake4(input logic [5:0] t0, input logic [5:0] t1,
                         input logic [5:0] t2, input logic [5:0] t3);
        wakeup_0_active = (t0 != 0); wakeup_0_tag = t0;
        wakeup_1_active = (t1 != 0); wakeup_1_tag = t1;
        wakeup_2_active = (t2 != 0); wakeup_2_tag = t2;
        wakeup_3_active = (t3 != 0); wakeup_3_tag = t3;
    endtask

    // ---------------- directed scenarios
    initial begin : stim
        reset_n = 0;
        clr();
        tick(); tick();
        chk("rst_empty", rob_empty, 1);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_f1", freed_tag_1, 0);
        chk("rst_f2", freed_tag_2, 0);
        chk("rst_rc", retire_count, 0);
        chk("rst_idx", alloc_index, 0);
        reset_n = 1;
        tick();

        // single entry, woken two cycles after allocation
        alloc(32, 5); tick(); clr();
        tick();
        wake4(32, 0, 0, 0); tick(); clr();
        if (!BYP) tick();
        chk("t2_f1", freed_tag_1, 5);
        chk("t2_f2", freed_tag_2, 0);
        chk("t2_rc", retire_count, 1);
        chk("t2_empty", rob_empty, 1);
        tick();
        chk("t2_rc_after", retire_count, 0);

        // younger woken first must wait for head
        alloc(32, 5); tick();
        alloc(33, 6); tick(); clr();
        wake4(33, 0, 0, 0); tick(); clr();
        tick();
        chk("t3_hold_rc", retire_count, 0);
        chk("t3_hold_empty", rob_empty, 0);
        wake4(32, 0, 0, 0); tick(); clr();
        if (!BYP) tick();
        chk("t3_f1", freed_tag_1, 5);
        chk("t3_f2", freed_tag_2, 6);
        chk("t3_rc", retire_count, 2);

        // fill, drop overflow, free head, wrap
        for (int i = 0; i < 16; i++) begin
            alloc(6'(i + 1), 6'(i + 20)); tick();
        end
        clr();
        chk("t4_full", rob_full, 1);
        chk("t4_ready", alloc_ready, 0);
        chk("t4_idx", alloc_index, 3);
        alloc(50, 50); tick(); clr();
        chk("t4_drop_full", rob_full, 1);
        chk("t4_drop_idx", alloc_index, 3);
        wake4(1, 0, 0, 0); tick(); clr();
        if (!BYP) tick();
        chk("t4_f1", freed_tag_1, 20);
        chk("t4_rc", retire_count, 1);
        chk("t4_ready_after", alloc_ready, 1);
        alloc(51, 60); tick(); clr();
        chk("t4_idx_wrap", alloc_index, 4);
        chk("t4_refull", rob_full, 1);
        wake4(2, 3, 4, 5); tick();
        wake4(6, 7, 8, 9); tick();
        wake4(10, 11, 12, 13); tick();
        wake4(14, 15, 16, 51); tick(); clr();
        repeat (10) tick();
        chk("t4_drained", rob_empty, 1);

        // rd = x0 retires on the following edge; tag-0 broadcast is inert
        alloc(0, 0); tick(); clr();
        chk("t5_live", rob_empty, 0);
        tick();
        chk("t5_rc", retire_count, 1);
        chk("t5_f1", freed_tag_1, 0);
        chk("t5_empty", rob_empty, 1);
        alloc(45, 9); tick(); clr();
        wakeup_0_active = 1; wakeup_1_active = 1; wakeup_2_active = 1; wakeup_3_active = 1;
        tick(); clr();
        tick();
        chk("t5_tag0_rc", retire_count, 0);
        chk("t5_tag0_empty", rob_empty, 0);
        wake4(45, 0, 0, 0); tick(); clr();
        repeat (2) tick();
        chk("t5_drain", rob_empty, 1);

        // wakeup on the allocation edge does not mark the new entry
        alloc(70, 11); wake4(70, 0, 0, 0); tick(); clr();
        tick(); tick();
        chk("t6_same_edge_rc", retire_count, 0);
        chk("t6_same_edge_empty", rob_empty, 0);
        wake4(70, 0, 0, 0); tick(); clr();
        repeat (2) tick();
        // alloc concurrent with 2-wide retire
        alloc(71, 12); tick();
        alloc(72, 13); tick();
        alloc(73, 14); wake4(71, 72, 0, 0); tick(); clr();
        repeat (2) tick();
        wake4(73, 0, 0, 0); tick(); clr();
        repeat (2) tick();
        chk("t6_empty", rob_empty, 1);

        // asynchronous reset with live entries frees nothing
        alloc(60, 1); tick();
        alloc(61, 2); tick();
        alloc(62, 3); tick(); clr();
        #1 reset_n = 0;
        #1;
        chk("t7_async_empty", rob_empty, 1);
        chk("t7_async_idx", alloc_index, 0);
        chk("t7_async_rc", retire_count, 0);
        #1 reset_n = 1;
        tick();
        chk("t7_rc", retire_count, 0);
        chk("t7_f1", freed_tag_1, 0);
        chk("t7_empty", rob_empty, 1);
        wake4(60, 61, 62, 0); tick(); clr();
        tick();
        chk("t7_stale_rc", retire_count, 0);
        chk("t7_stale_f1", freed_tag_1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
